gal_jed_loader: RTL

Streaming JEDEC fuse-map reader for the GAL emulation flow. It consumes the ASCII `.jed` byte stream that the fitter emits and decodes the `L` (fuse list) fields into single-bit writes on an external fuse RAM. That RAM holds the `TABLE`, `REGISTERED` and `INVERTED` configuration of the emulated SOP/OLMC array. The block also accumulates the JEDEC fuse checksum and, optionally, checks it against the file's `C` field.

---
 rtl/gal_jed_pkg.sv | 49 ++++
 rtl/gal_jed_csum.sv | 24 ++
 rtl/gal_jed_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gal_jed_pkg.sv
// Shared types and constants for the JEDEC fuse-map loader.
package gal_jed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIELD,
    ST_ADDR,
    ST_BITS,
    ST_HEX,
    ST_SKIP,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CHAR  = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam logic [7:0] CH_STX  = 8'h02;
  localparam logic [7:0] CH_ETX  = 8'h03;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_TAB  = 8'h09;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  function automatic logic is_ws(input logic [7:0] b);
    return (b == CH_SP) || (b == CH_TAB) || (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic logic is_dec(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Returns {valid, nibble} for 0-9, A-F, a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = '0;
    if (is_dec(b))
      r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, 4'(b[3:0] + 4'd9)};
    return r;
  endfunction

endpackage

// File: rtl/gal_jed_csum.sv
// JEDEC fuse checksum accumulator: adds (d << addr[2:0]) per fuse write.
module gal_jed_csum (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        we_i,
  input  logic [2:0]  addr_i,
  input  logic        d_i,
  output logic [15:0] csum_o
);

  logic [15:0] acc_q;

  // Accumulate each set fuse at its byte-lane weight; clear on reset or stream start.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)
      acc_q <= '0;
    else if (we_i && d_i)
      acc_q <= acc_q + (16'd1 << addr_i);
  end

  assign csum_o = acc_q;

endmodule

// File: rtl/gal_jed_loader.sv
// Streaming JEDEC .jed reader: decodes L fields into fuse RAM writes.
// Optional macro GAL_JED_CHECKSUM_EN builds the C-field checksum check.
module gal_jed_loader
  import gal_jed_pkg::*;
#(
  parameter  int unsigned FUSES = 2194,
  localparam int unsigned AW    = $clog2(FUSES)
) (
  input  logic          C,
  input  logic          R,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          fuse_we,
  output logic [AW-1:0] fuse_addr,
  output logic          fuse_d,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [15:0]   csum
);

  state_t          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic            seen_q, seen_d;
  logic            fuse_we_q, fuse_we_d;
  logic [AW-1:0]   fuse_addr_q, fuse_addr_d;
  logic            fuse_d_q, fuse_d_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [19:0]     dec;
`ifdef GAL_JED_CHECKSUM_EN
  logic [15:0]     hex_q, hex_d;
  logic [2:0]      hex_cnt_q, hex_cnt_d;
  logic [4:0]      hexv;
  logic            csum_clr;
  logic [15:0]     csum_w;
`endif

  // State register and registered fuse-write outputs.
  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      seen_q      <= 1'b0;
      fuse_we_q   <= 1'b0;
      fuse_addr_q <= '0;
      fuse_d_q    <= 1'b0;
      err_code_q  <= ERR_NONE;
`ifdef GAL_JED_CHECKSUM_EN
      hex_q       <= '0;
      hex_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seen_q      <= seen_d;
      fuse_we_q   <= fuse_we_d;
      fuse_addr_q <= fuse_addr_d;
      fuse_d_q    <= fuse_d_d;
      err_code_q  <= err_code_d;
`ifdef GAL_JED_CHECKSUM_EN
      hex_q       <= hex_d;
      hex_cnt_q   <= hex_cnt_d;
`endif
    end
  end

  // Next-state decode of one accepted byte.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seen_d      = seen_q;
    fuse_we_d   = 1'b0;
    fuse_addr_d = fuse_addr_q;
    fuse_d_d    = fuse_d_q;
    err_code_d  = err_code_q;
    dec         = ({4'b0, addr_q} * 20'd10) + {16'b0, in_data[3:0]};
`ifdef GAL_JED_CHECKSUM_EN
    hex_d       = hex_q;
    hex_cnt_d   = hex_cnt_q;
    hexv        = hex_decode(in_data);
    csum_clr    = 1'b0;
`endif
    if (in_valid) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (in_data == CH_STX) begin
            state_d    = ST_SKIP;
            addr_d     = '0;
            seen_d     = 1'b0;
            err_code_d = ERR_NONE;
`ifdef GAL_JED_CHECKSUM_EN
            hex_d      = '0;
            hex_cnt_d  = '0;
            csum_clr   = 1'b1;
`endif
          end
        end
        ST_FIELD: begin
          if (!is_ws(in_data)) begin
            if (in_data == CH_L) begin
              state_d = ST_ADDR;
              addr_d  = '0;
              seen_d  = 1'b0;
            end
`ifdef GAL_JED_CHECKSUM_EN
            else if (in_data == CH_C) begin
              state_d   = ST_HEX;
              hex_d     = '0;
              hex_cnt_d = '0;
            end
`endif
            else if (in_data == CH_ETX)
              state_d = ST_DONE;
            else
              state_d = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (in_data == CH_STAR)
            state_d = ST_FIELD;
          else if (in_data == CH_ETX)
            state_d = ST_DONE;
        end
        ST_ADDR: begin
          if (is_dec(in_data)) begin
            addr_d = (dec > 20'hFFFF) ? 16'hFFFF : dec[15:0];
            seen_d = 1'b1;
          end else if (is_ws(in_data)) begin
            if (seen_q)
              state_d = ST_BITS;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CHAR;
          end
        end
        ST_BITS: begin
          if (in_data == 8'h30 || in_data == 8'h31) begin
            if (32'(addr_q) >= FUSES) begin
              state_d    = ST_ERR;
              err_code_d = ERR_RANGE;
            end else begin
              fuse_we_d   = 1'b1;
              fuse_addr_d = addr_q[AW-1:0];
              fuse_d_d    = in_data[0];
              addr_d      = addr_q + 16'd1;
            end
          end else if (in_data == CH_STAR)
            state_d = ST_FIELD;
          else if (in_data == CH_ETX)
            state_d = ST_DONE;
          else if (!is_ws(in_data)) begin
            state_d    = ST_ERR;
            err_code_d = ERR_CHAR;
          end
        end
`ifdef GAL_JED_CHECKSUM_EN
        // Whitespace is tolerated only before the first digit or after the fourth.
        ST_HEX: begin
          if (hexv[4]) begin
            if (hex_cnt_q == 3'd4) begin
              state_d    = ST_ERR;
              err_code_d = ERR_CHAR;
            end else begin
              hex_d     = {hex_q[11:0], hexv[3:0]};
              hex_cnt_d = hex_cnt_q + 3'd1;
            end
          end else if (is_ws(in_data)) begin
            if (hex_cnt_q != 3'd0 && hex_cnt_q != 3'd4) begin
              state_d    = ST_ERR;
              err_code_d = ERR_CHAR;
            end
          end else if (in_data == CH_STAR) begin
            if (hex_cnt_q != 3'd4) begin
              state_d    = ST_ERR;
              err_code_d = ERR_CHAR;
            end else if (hex_q != csum_w) begin
              state_d    = ST_ERR;
              err_code_d = ERR_CSUM;
            end else
              state_d = ST_FIELD;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CHAR;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Status outputs derived from the current state.
  always_comb begin
    in_ready  = 1'b1;
    fuse_we   = fuse_we_q;
    fuse_addr = fuse_addr_q;
    fuse_d    = fuse_d_q;
    busy      = (state_q == ST_FIELD) || (state_q == ST_ADDR) || (state_q == ST_BITS) ||
                (state_q == ST_HEX)   || (state_q == ST_SKIP);
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_ERR);
    err_code  = (state_q == ST_ERR) ? err_code_q : ERR_NONE;
  end

`ifdef GAL_JED_CHECKSUM_EN
  // The accumulator takes the write in the same edge that registers it, so
  // csum already covers a write in the cycle fuse_we is shown.
  gal_jed_csum u_csum (
    .clk_i  (C),
    .rst_i  (R),
    .clr_i  (csum_clr),
    .we_i   (fuse_we_d),
    .addr_i (fuse_addr_d[2:0]),
    .d_i    (fuse_d_d),
    .csum_o (csum_w)
  );
  assign csum = csum_w;
`else
  assign csum = '0;
`endif

endmodule
